rsa_operand_loader: RTL

RSA_OPERAND_LOADER -- requirements
Module: rsa_operand_loader

---
 rtl/rsa_pkg.sv | 36 +++
 rtl/rsa_result_serializer.sv | 56 +++++
 rtl/rsa_operand_loader.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA operand loader: default widths, operand
// select encodings, the loader FSM state type and a select decoder.
package rsa_pkg;

   localparam int KEY_W_DEF  = 1024;
   localparam int WORD_W_DEF = 32;

   localparam logic [2:0] SEL_MSG    = 3'd0;
   localparam logic [2:0] SEL_N      = 3'd1;
   localparam logic [2:0] SEL_RMODN  = 3'd2;
   localparam logic [2:0] SEL_R2MODN = 3'd3;
   localparam logic [2:0] SEL_EXP    = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_DRAIN
   } loader_state_t;

   // One-hot loaded-mask bit for a select code; illegal codes map to no bit.
   function automatic logic [4:0] sel_onehot(input logic [2:0] sel);
      logic [4:0] oh;
      oh = 5'b00000;
      case (sel)
         SEL_MSG:    oh = 5'b00001;
         SEL_N:      oh = 5'b00010;
         SEL_RMODN:  oh = 5'b00100;
         SEL_R2MODN: oh = 5'b01000;
         SEL_EXP:    oh = 5'b10000;
         default:    oh = 5'b00000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/rsa_result_serializer.sv
// Captures the exponentiation result and streams it out LSW first over a
// valid/ready interface, one WORD_W slice per handshake.
module rsa_result_serializer
   import rsa_pkg::*;
#(
   parameter int KEY_W  = KEY_W_DEF,
   parameter int WORD_W = WORD_W_DEF
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              capture,
   input  logic [KEY_W-1:0]  result,
   input  logic              m_ready,
   output logic              m_valid,
   output logic [WORD_W-1:0] m_data,
   output logic              m_last,
   output logic              drain_done
);

   localparam int NW    = KEY_W / WORD_W;
   localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;

   logic [KEY_W-1:0] shreg;
   logic [CNT_W-1:0] word_cnt;

   assign m_data     = shreg[WORD_W-1:0];
   assign drain_done = m_valid && m_ready && m_last;

   // The shift register only advances on a handshake, so m_data/m_last hold
   // while the consumer stalls; it is zeroed after the last word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg    <= '0;
         word_cnt <= '0;
         m_valid  <= 1'b0;
         m_last   <= 1'b0;
      end else if (capture) begin
         shreg    <= result;
         word_cnt <= '0;
         m_valid  <= 1'b1;
         m_last   <= (NW == 1);
      end else if (m_valid && m_ready) begin
         if (m_last) begin
            shreg    <= '0;
            word_cnt <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
         end else begin
            shreg    <= shreg >> WORD_W;
            word_cnt <= word_cnt + 1'b1;
            m_last   <= (word_cnt == CNT_W'(NW - 2));
         end
      end
   end

endmodule

// File: rtl/rsa_operand_loader.sv
// Loads RSA operands word by word, launches montgomery_exp and streams the
// result back. Define RSA_LOADER_KEY_REUSE_EN to keep key operands across runs.
module rsa_operand_loader
   import rsa_pkg::*;
#(
   parameter int KEY_W  = KEY_W_DEF,
   parameter int WORD_W = WORD_W_DEF
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_data,
   input  logic [2:0]        s_sel,
   input  logic              s_last,
   input  logic              go,
   output logic [KEY_W-1:0]  msg,
   output logic [KEY_W-1:0]  n,
   output logic [KEY_W-1:0]  rmodn,
   output logic [KEY_W-1:0]  r2modn,
   output logic [15:0]       exp,
   output logic              exp_start,
   input  logic              exp_done,
   input  logic [KEY_W-1:0]  exp_result,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [WORD_W-1:0] m_data,
   output logic              m_last,
   output logic              busy,
   output logic              err
);

   localparam int NW    = KEY_W / WORD_W;
   localparam int CNT_W = $clog2(NW + 1);
   localparam logic [4:0] MASK_FULL = 5'b11111;
`ifdef RSA_LOADER_KEY_REUSE_EN
   localparam logic [4:0] MASK_KEEP = 5'b11110;
`else
   localparam logic [4:0] MASK_KEEP = 5'b00000;
`endif

   loader_state_t    state;
   logic [CNT_W-1:0] word_cnt;
   logic [2:0]       cur_sel;
   logic [4:0]       loaded_mask;
   logic [4:0]       sel_oh;
   logic             word_fire;
   logic             word_err;
   logic             word_final;
   logic             capture;
   logic             drain_done;

   assign word_fire = s_valid && s_ready;
   assign sel_oh    = sel_onehot(s_sel);
   assign capture   = (state == ST_WAIT) && exp_done;

   // Classify the presented word: protocol violation, final word, or a
   // middle word of a wide operand (neither flag set).
   always_comb begin
      word_err   = 1'b0;
      word_final = 1'b0;
      if (s_sel > SEL_EXP) begin
         word_err = 1'b1;
      end else if ((word_cnt != '0) && (s_sel != cur_sel)) begin
         word_err = 1'b1;
      end else if (s_sel == SEL_EXP) begin
         if (s_last) word_final = 1'b1;
         else        word_err   = 1'b1;
      end else if (word_cnt >= CNT_W'(NW)) begin
         word_err = 1'b1;
      end else if (s_last) begin
         if (word_cnt == CNT_W'(NW - 1)) word_final = 1'b1;
         else                            word_err   = 1'b1;
      end
   end

   // A partially rewritten operand is no longer valid, so its mask bit drops
   // on every non-final word and is only restored by a clean final word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         msg         <= '0;
         n           <= '0;
         rmodn       <= '0;
         r2modn      <= '0;
         exp         <= '0;
         word_cnt    <= '0;
         cur_sel     <= SEL_MSG;
         loaded_mask <= '0;
      end else if (drain_done) begin
         loaded_mask <= loaded_mask & MASK_KEEP;
      end else if (word_fire) begin
         if (word_err) begin
            word_cnt    <= '0;
            loaded_mask <= loaded_mask & ~sel_oh;
         end else begin
            case (s_sel)
               SEL_MSG:    msg[WORD_W*int'(word_cnt) +: WORD_W]    <= s_data;
               SEL_N:      n[WORD_W*int'(word_cnt) +: WORD_W]      <= s_data;
               SEL_RMODN:  rmodn[WORD_W*int'(word_cnt) +: WORD_W]  <= s_data;
               SEL_R2MODN: r2modn[WORD_W*int'(word_cnt) +: WORD_W] <= s_data;
               SEL_EXP:    exp <= s_data[15:0];
               default:    ;
            endcase
            if (word_final) begin
               word_cnt    <= '0;
               loaded_mask <= loaded_mask | sel_oh;
            end else begin
               word_cnt    <= word_cnt + 1'b1;
               cur_sel     <= s_sel;
               loaded_mask <= loaded_mask & ~sel_oh;
            end
         end
      end
   end

   // Control FSM; go is judged against the mask as it stood before any word
   // accepted in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         s_ready   <= 1'b0;
         busy      <= 1'b0;
         exp_start <= 1'b0;
         err       <= 1'b0;
      end else begin
         exp_start <= 1'b0;
         if (word_fire && word_err) err <= 1'b1;
         case (state)
            ST_IDLE: begin
               s_ready <= 1'b1;
               if (go) begin
                  if (loaded_mask == MASK_FULL) begin
                     state     <= ST_START;
                     exp_start <= 1'b1;
                     busy      <= 1'b1;
                     s_ready   <= 1'b0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ST_START: state <= ST_WAIT;
            ST_WAIT: begin
               if (exp_done) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (drain_done) begin
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
                  s_ready <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   rsa_result_serializer #(
      .KEY_W  (KEY_W),
      .WORD_W (WORD_W)
   ) u_serializer (
      .clk        (clk),
      .reset      (reset),
      .capture    (capture),
      .result     (exp_result),
      .m_ready    (m_ready),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_last     (m_last),
      .drain_done (drain_done)
   );

endmodule
